// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: controller states,
// default geometry and the fixed response returned for misaligned fetches.
package mem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 512;
    localparam int unsigned DATA_BASE_DEF = 256;
    localparam logic [15:0] MISALIGN_RSP  = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_D_ACC = 3'd1,
        ST_I_LO  = 3'd2,
        ST_I_HI  = 3'd3,
        ST_I_RSP = 3'd4
    } state_t;

endpackage

// File: rtl/mem_responder_ram_sp.sv
// Single-port byte-wide synchronous RAM; a write also returns the written
// byte on rdata, and the array itself is never reset.
module ram_sp
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_BYTES_DEF
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
                r_rdata     <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Arbitrates a 16-bit instruction fetch port and an 8-bit data port onto
// one single-ported byte RAM; data requests win when both are valid.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned DATA_BASE = DATA_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_addr,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    output logic        if_misalign,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_rvalid,
    output logic [7:0]  d_rdata
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    state_t          r_state, w_next;
    logic            r_we, r_d_rvalid, r_if_rvalid, r_if_mis;
    logic [AW-1:0]   r_didx, r_fidx;
    logic [7:0]      r_wdata, r_lo, r_d_hold;
    logic [15:0]     r_if_hold;
    logic            w_idle, w_d_acc, w_if_acc, w_ram_en, w_ram_we;
    logic [AW-1:0]   w_ram_addr, w_didx;
    logic [7:0]      w_ram_rdata;
    logic            w_unused_addr;

    assign w_idle        = reset && (r_state == ST_IDLE);
    assign d_ready       = w_idle;
    assign if_ready      = w_idle && !d_valid;
    assign w_d_acc       = d_valid && d_ready;
    assign w_if_acc      = if_valid && if_ready;
    assign w_didx        = AW'(DATA_BASE) + AW'(d_addr);
    assign w_unused_addr = ^if_addr[15:AW];

    // RAM enable is gated by reset so a store caught by reset is never written.
    always_comb begin
        w_next     = r_state;
        w_ram_en   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_addr = r_fidx;
        case (r_state)
            ST_IDLE: begin
                if (w_d_acc)       w_next = ST_D_ACC;
                else if (w_if_acc) w_next = if_addr[0] ? ST_I_RSP : ST_I_LO;
            end
            ST_D_ACC: begin
                w_next     = ST_IDLE;
                w_ram_en   = reset;
                w_ram_we   = r_we;
                w_ram_addr = r_didx;
            end
            ST_I_LO: begin
                w_next   = ST_I_HI;
                w_ram_en = reset;
            end
            ST_I_HI: begin
                w_next     = ST_IDLE;
                w_ram_en   = reset;
                w_ram_addr = r_fidx + AW'(1);
            end
            ST_I_RSP: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_d_rvalid  <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_mis    <= 1'b0;
            r_d_hold    <= '0;
            r_if_hold   <= '0;
        end else begin
            r_state     <= w_next;
            r_d_rvalid  <= (r_state == ST_D_ACC);
            r_if_rvalid <= (r_state == ST_I_HI) || (w_if_acc && if_addr[0]);
            if (r_d_rvalid)                r_d_hold  <= w_ram_rdata;
            if (r_if_rvalid && !r_if_mis)  r_if_hold <= {w_ram_rdata, r_lo};
            if (r_state == ST_I_HI) begin
                r_if_mis <= 1'b0;
                r_lo     <= w_ram_rdata;
            end
            // Odd accept may coincide with an even response; it must win the hold.
            if (w_if_acc && if_addr[0]) begin
                r_if_mis  <= 1'b1;
                r_if_hold <= MISALIGN_RSP;
            end
            if (w_d_acc) begin
                r_we    <= d_we;
                r_didx  <= w_didx;
                r_wdata <= d_wdata;
            end
            if (w_if_acc) r_fidx <= if_addr[AW-1:0];
        end
    end

    ram_sp #(.DEPTH(MEM_BYTES)) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // Responses come straight from the RAM output during rvalid, else the held copy.
    assign d_rvalid    = r_d_rvalid;
    assign d_rdata     = r_d_rvalid ? w_ram_rdata : r_d_hold;
    assign if_rvalid   = r_if_rvalid;
    assign if_misalign = r_if_mis;
    assign if_rdata    = (r_if_rvalid && !r_if_mis) ? {w_ram_rdata, r_lo} : r_if_hold;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed corner cases plus a random
// mix of loads, stores and fetches checked against a byte-array model.
module tb_mem_responder;

    localparam int MB = 512;
    localparam int DB = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, if_ready, if_rvalid, if_misalign;
    logic [15:0] if_addr, if_rdata;
    logic        d_valid, d_ready, d_we, d_rvalid;
    logic [7:0]  d_addr, d_wdata, d_rdata;

    logic [7:0]  mem_m [MB];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.MEM_BYTES(512), .DATA_BASE(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_addr     (if_addr),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .if_misalign (if_misalign),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic data_req(input logic we, input logic [7:0] a, input logic [7:0] wd,
                            input string tag);
        int   idx;
        int   lat;
        logic [7:0] exp;
        idx = (DB + int'(a)) % MB;
        if (we) mem_m[idx] = wd;
        exp = mem_m[idx];
        @(negedge clk);
        d_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        #1 check({tag, ".d_ready"}, 32'(d_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                d_valid = 1'b0; d_addr = 8'($urandom); d_wdata = 8'($urandom);
            end
            #1 if (d_rvalid) lat = k;
        end
        check({tag, ".d_lat"}, 32'(lat), 32'd2);
        check({tag, ".d_rdata"}, 32'(d_rdata), 32'(exp));
        @(negedge clk);
        #1 check({tag, ".d_rvalid_drop"}, 32'(d_rvalid), 32'd0);
        check({tag, ".d_rdata_hold"}, 32'(d_rdata), 32'(exp));
    endtask

    task automatic fetch_req(input logic [15:0] a, input string tag);
        int          idx;
        int          lat;
        logic [15:0] exp;
        idx = int'(a) % MB;
        exp = a[0] ? 16'h0000 : {mem_m[(idx + 1) % MB], mem_m[idx]};
        @(negedge clk);
        if_valid = 1'b1; if_addr = a;
        #1 check({tag, ".if_ready"}, 32'(if_ready), 32'd1);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if_valid = 1'b0; if_addr = 16'($urandom);
            end
            #1 if (if_rvalid) lat = k;
        end
        check({tag, ".if_lat"}, 32'(lat), a[0] ? 32'd1 : 32'd3);
        check({tag, ".if_rdata"}, 32'(if_rdata), 32'(exp));
        check({tag, ".if_misalign"}, 32'(if_misalign), 32'(a[0]));
        @(negedge clk);
        #1 check({tag, ".if_rvalid_drop"}, 32'(if_rvalid), 32'd0);
        check({tag, ".if_rdata_hold"}, 32'(if_rdata), 32'(exp));
    endtask

    initial begin
        int          dl, il, ia, seen;
        logic        drop;
        logic [15:0] fexp, fdata;
        logic [7:0]  dexp, old;

        reset = 1'b0; if_valid = 1'b0; if_addr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst.if_ready", 32'(if_ready), 32'd0);
        check("rst.d_ready", 32'(d_ready), 32'd0);
        check("rst.if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst.d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst.if_misalign", 32'(if_misalign), 32'd0);
        check("rst.if_rdata", 32'(if_rdata), 32'd0);
        check("rst.d_rdata", 32'(d_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rel.d_ready", 32'(d_ready), 32'd1);
        check("rel.if_ready", 32'(if_ready), 32'd1);

        // Fill the whole data window so every later read has a known value.
        for (int i = 0; i < 256; i++) data_req(1'b1, 8'(i), 8'($urandom), "fill");

        data_req(1'b1, 8'h05, 8'hA7, "st05");
        data_req(1'b0, 8'h05, 8'h00, "ld05");
        data_req(1'b1, 8'h10, 8'h34, "st10");
        data_req(1'b1, 8'h11, 8'h12, "st11");
        fetch_req(16'h0110, "f0110");
        check("f0110.value", 32'(if_rdata), 32'h1234);
        fetch_req(16'h0310, "f0310_wrap");
        fetch_req(16'hFF10, "fFF10_wrap");
        fetch_req(16'h0113, "f0113_odd");
        fetch_req(16'h0112, "f0112_after_odd");
        data_req(1'b1, 8'hFF, 8'h5A, "stFF");
        fetch_req(16'h01FE, "f01FE_top");
        check("f01FE.hi", 32'(if_rdata[15:8]), 32'h5A);
        fetch_req(16'h01FF, "f01FF_odd");

        // Simultaneous data and fetch: data first, fetch accepted when idle again.
        dexp = mem_m[(DB + 16'h10) % MB];
        fexp = {mem_m[16'h113], mem_m[16'h112]};
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b0; d_addr = 8'h10; if_valid = 1'b1; if_addr = 16'h0112;
        #1 check("both.if_ready", 32'(if_ready), 32'd0);
        check("both.d_ready", 32'(d_ready), 32'd1);
        @(posedge clk);
        dl = 0; il = 0; ia = 0; drop = 1'b0; fdata = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) d_valid = 1'b0;
            if (drop) if_valid = 1'b0;
            drop = 1'b0;
            #1;
            if (d_rvalid && dl == 0) begin
                dl = k;
                check("both.d_rdata", 32'(d_rdata), 32'(dexp));
            end
            if (if_rvalid && il == 0) begin
                il = k; fdata = if_rdata;
            end
            if (if_valid && if_ready && ia == 0) begin
                ia = k; drop = 1'b1;
            end
        end
        check("both.d_lat", 32'(dl), 32'd2);
        check("both.if_acc", 32'(ia), 32'd2);
        check("both.if_lat", 32'(il), 32'd5);
        check("both.if_rdata", 32'(fdata), 32'(fexp));

        // Reset during D_ACC of a store: no response, byte unchanged.
        old = mem_m[DB + 16'h20];
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = ~old;
        #1 check("rst_st.d_ready", 32'(d_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0; reset = 1'b0;
        #1 check("rst_st.d_ready_low", 32'(d_ready), 32'd0);
        check("rst_st.if_ready_low", 32'(if_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_st.d_ready_rel", 32'(d_ready), 32'd1);
        check("rst_st.if_ready_rel", 32'(if_ready), 32'd1);
        check("rst_st.d_rdata", 32'(d_rdata), 32'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            #1 if (d_rvalid) seen++;
            @(negedge clk);
        end
        check("rst_st.no_rvalid", 32'(seen), 32'd0);
        data_req(1'b0, 8'h20, 8'h00, "rst_st.reload");

        // Reset while a fetch is in I_LO drops the response.
        @(negedge clk);
        if_valid = 1'b1; if_addr = 16'h0140;
        @(posedge clk);
        @(negedge clk);
        if_valid = 1'b0; reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            #1 if (if_rvalid) seen++;
            @(negedge clk);
        end
        check("rst_f.no_rvalid", 32'(seen), 32'd0);
        check("rst_f.if_rdata", 32'(if_rdata), 32'd0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: data_req(1'b1, 8'($urandom), 8'($urandom), "rnd_st");
                1: data_req(1'b0, 8'($urandom), 8'($urandom), "rnd_ld");
                2: fetch_req({7'($urandom), 1'b1, 7'($urandom), 1'b0}, "rnd_fe");
                default: fetch_req({15'($urandom), 1'b1}, "rnd_fo");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
